// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the reduction sequencer's state encoding.
package fp16_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_OVF  = 16'hFFFF;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  // Cycles from issuing a pair to the adder until its result returns.
  localparam int FP16_ADD_LAT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fp16_sum_seq.sv
// Reduces an in_last-terminated stream of FP16 values to one sum by pairing
// raw operands and returned partial sums onto a pipelined FP16 adder.
// At most one pair is issued per cycle, so a single spare register suffices.
module fp16_sum_seq
  import fp16_pkg::*;
#(
  parameter int LAT   = FP16_ADD_LAT,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_valid,
  input  logic [15:0] add_result,
  input  logic        add_update,
  output logic [15:0] sum_data,
  output logic        sum_valid,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LAT);

  seq_state_e       state_q, state_d;
  logic [15:0]      spare_q, spare_d;
  logic             spare_vld_q, spare_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      add_a_q, add_a_d;
  logic [15:0]      add_b_q, add_b_d;
  logic             add_valid_q, add_valid_d;
  logic [15:0]      sum_data_q, sum_data_d;
  logic             sum_valid_q, sum_valid_d;
  logic             err_q, err_d;

  logic             acc_s;
  logic             r_ok_s;
  logic             i_ok_s;
  logic             issue_s;
  logic [15:0]      iss_a_s;
  logic [15:0]      iss_b_s;

  // Pairing of return/beat/spare, state transitions, in-flight tracking and error capture.
  always_comb begin
    state_d     = state_q;
    spare_d     = spare_q;
    spare_vld_d = spare_vld_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sum_data_d  = sum_data_q;
    issue_s     = 1'b0;
    iss_a_s     = FP16_ZERO;
    iss_b_s     = FP16_ZERO;

    acc_s  = in_valid & in_ready_q;
    // A return is only usable while a burst is active and something is in flight.
    r_ok_s = add_update & ((state_q == ST_ACCUM) | (state_q == ST_DRAIN)) & (cnt_q != CNT_ZERO);
    i_ok_s = acc_s & (state_q == ST_ACCUM);

    // Unexpected returns are discarded and flagged.
    if (add_update && !r_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    // Pair the available sources; the spare absorbs a lone operand.
    if (r_ok_s && i_ok_s) begin
      issue_s = 1'b1;
      iss_a_s = add_result;
      iss_b_s = in_data;
    end else if (r_ok_s) begin
      if (spare_vld_q) begin
        issue_s     = 1'b1;
        iss_a_s     = spare_q;
        iss_b_s     = add_result;
        spare_vld_d = 1'b0;
      end else begin
        spare_d     = add_result;
        spare_vld_d = 1'b1;
      end
    end else if (i_ok_s) begin
      if (spare_vld_q) begin
        issue_s     = 1'b1;
        iss_a_s     = spare_q;
        iss_b_s     = in_data;
        spare_vld_d = 1'b0;
      end else begin
        spare_d     = in_data;
        spare_vld_d = 1'b1;
      end
    end else begin
      issue_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (acc_s) begin
          if (in_last) begin
            state_d    = ST_DONE;
            sum_data_d = in_data;
          end else begin
            state_d     = ST_ACCUM;
            spare_d     = in_data;
            spare_vld_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (i_ok_s && in_last) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        // The spare holds the final sum once nothing is in flight or arriving.
        if ((cnt_q == CNT_ZERO) && !add_update && spare_vld_q) begin
          state_d     = ST_DONE;
          sum_data_d  = spare_q;
          spare_vld_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        spare_vld_d = 1'b0;
      end
    endcase

    // In-flight count: saturates at LAT so an impossible overshoot is flagged, not wrapped.
    if (issue_s && !r_ok_s) begin
      if (cnt_q == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!issue_s && r_ok_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next values for the registered outputs.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE) | (state_d == ST_ACCUM);
    add_valid_d = issue_s;
    sum_valid_d = (state_d == ST_DONE);
    if (issue_s) begin
      add_a_d = iss_a_s;
      add_b_d = iss_b_s;
    end else begin
      add_a_d = add_a_q;
      add_b_d = add_b_q;
    end
  end

  // State, spare and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      spare_q     <= FP16_ZERO;
      spare_vld_q <= 1'b0;
      cnt_q       <= CNT_ZERO;
      err_q       <= 1'b0;
      sum_data_q  <= FP16_ZERO;
    end else begin
      state_q     <= state_d;
      spare_q     <= spare_d;
      spare_vld_q <= spare_vld_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sum_data_q  <= sum_data_d;
    end
  end

  // Output handshake and adder issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      add_a_q     <= FP16_ZERO;
      add_b_q     <= FP16_ZERO;
      add_valid_q <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_valid_q <= add_valid_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_valid = add_valid_q;
  assign sum_data  = sum_data_q;
  assign sum_valid = sum_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fp16_sum_seq.sv
// Bench for fp16_sum_seq: behavioural FP16 adder with configurable latency,
// table vectors, a forced R/I coincidence sequence, random bursts and reset abort.
module tb_fp16_sum_seq;
  import fp16_pkg::*;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] add_a, add_b;
  logic        add_valid;
  logic [15:0] add_result;
  logic        add_update;
  logic [15:0] sum_data;
  logic        sum_valid;
  logic        err;

  fp16_sum_seq #(.LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .add_a(add_a), .add_b(add_b),
    .add_valid(add_valid), .add_result(add_result), .add_update(add_update),
    .sum_data(sum_data), .sum_valid(sum_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct { int due; logic [15:0] d; } pend_t;
  pend_t        pend[$];
  logic [31:0]  iss_q[$];
  int           adder_lat = LAT;
  bit           stray_req = 1'b0;
  int           ncyc = 0;
  int           sumv_cnt = 0;
  int           last_wait = 0;

  typedef struct {
    int          n;
    logic [15:0] b [8];
    logic [15:0] exp_sum;
    int          exp_iss;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_dec(input logic [15:0] h);
    int e;
    int f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return real'(f) * pow2(-24);
    return (1.0 + real'(f) / 1024.0) * pow2(e - 15);
  endfunction

  function automatic logic [15:0] fp_enc(input real r);
    int  e;
    int  be;
    int  f;
    real m;
    if (r == 0.0) return 16'h0000;
    if (r > 65504.0) return 16'hFFFF;
    e = 0;
    m = r;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    be = e + 15;
    if (be <= 0) begin
      f = $rtoi(r * pow2(24) + 0.5);
      return 16'(f);
    end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (f == 1024) begin f = 0; be++; end
    if (be >= 31) return 16'hFFFF;
    return {1'b0, 5'(be), 10'(f)};
  endfunction

  // Adder behaviour: an all-ones exponent on either side, or overflow, gives FFFF.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return 16'hFFFF;
    return fp_enc(fp_dec(a) + fp_dec(b));
  endfunction

  // Adder model and issue monitor, stepped mid-cycle.
  initial begin
    add_update = 1'b0;
    add_result = 16'h0000;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sum_valid) sumv_cnt++;
      if (!rst_n) begin
        pend.delete();
        add_update = 1'b0;
        add_result = 16'h0000;
      end else begin
        if (add_valid) begin
          iss_q.push_back({add_a, add_b});
          pend.push_back('{ncyc + adder_lat, fp_add(add_a, add_b)});
        end
        if (stray_req) begin
          add_update = 1'b1;
          add_result = 16'h3C00;
          stray_req  = 1'b0;
        end else if (pend.size() > 0 && pend[0].due == ncyc) begin
          add_update = 1'b1;
          add_result = pend[0].d;
          void'(pend.pop_front());
        end else begin
          add_update = 1'b0;
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input bit last);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (w >= 300) chk("beat_accept_timeout", 32'(w), 32'd0);
    @(posedge clk);
  endtask

  task automatic gap_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_sum(input string nm, output logic [15:0] d);
    bit got;
    got = 1'b0;
    d   = 16'h0000;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (sum_valid) begin
        got = 1'b1;
        d   = sum_data;
      end
    end
    if (!got) chk({nm, "_sum_timeout"}, 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk({nm, "_pulse_one_cycle"}, 32'(sum_valid), 32'd0);
    end
  endtask

  task automatic run_burst(input string nm, input logic [15:0] beats[$],
                           input logic [15:0] exp_sum, input int exp_iss, input bit gaps);
    logic [15:0] got;
    iss_q.delete();
    for (int i = 0; i < beats.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) gap_cycle();
      send_beat(beats[i], i == beats.size() - 1);
    end
    wait_sum(nm, got);
    chk({nm, "_sum"}, 32'(got), 32'(exp_sum));
    chk({nm, "_issues"}, 32'(iss_q.size()), 32'(exp_iss));
    chk({nm, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    vec_t        tbl [5];
    logic [15:0] bq[$];
    logic [15:0] got;
    int          n;
    int          v;
    int          tot;
    int          sv0;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;

    tbl[0].n = 1; tbl[0].b[0] = 16'h3C00;
    tbl[0].exp_sum = 16'h3C00; tbl[0].exp_iss = 0;
    tbl[1].n = 2; tbl[1].b[0] = 16'h3C00; tbl[1].b[1] = 16'h3C00;
    tbl[1].exp_sum = 16'h4000; tbl[1].exp_iss = 1;
    tbl[2].n = 3; tbl[2].b[0] = 16'h3C00; tbl[2].b[1] = 16'h4000; tbl[2].b[2] = 16'h4400;
    tbl[2].exp_sum = 16'h4700; tbl[2].exp_iss = 2;
    tbl[3].n = 2; tbl[3].b[0] = 16'h7BFF; tbl[3].b[1] = 16'h7BFF;
    tbl[3].exp_sum = 16'hFFFF; tbl[3].exp_iss = 1;
    tbl[4].n = 2; tbl[4].b[0] = 16'h4000; tbl[4].b[1] = 16'h4200;
    tbl[4].exp_sum = 16'h4500; tbl[4].exp_iss = 1;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_add_valid", 32'(add_valid), 32'd0);
    chk("rst_add_ab", {add_a, add_b}, 32'd0);
    chk("rst_sum", {15'd0, sum_valid, sum_data}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Table vectors.
    for (int t = 0; t < 5; t++) begin
      bq.delete();
      for (int i = 0; i < tbl[t].n; i++) bq.push_back(tbl[t].b[i]);
      run_burst($sformatf("vec%0d", t), bq, tbl[t].exp_sum, tbl[t].exp_iss, 1'b0);
    end

    // Eight back-to-back ones; a short adder latency makes the first
    // return land on beat 6 while beat 5 sits in the spare.
    adder_lat = 3;
    iss_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_beat(16'h3C00, i == 7);
      chk($sformatf("b2b_ready_beat%0d", i + 1), 32'(last_wait), 32'd0);
    end
    wait_sum("b2b", got);
    chk("b2b_sum", 32'(got), 32'h4800);
    chk("b2b_issues", 32'(iss_q.size()), 32'd7);
    chk("b2b_issue_R_I", (iss_q.size() > 2) ? iss_q[2] : 32'd0, 32'h40003C00);
    chk("b2b_spare_kept", (iss_q.size() > 3) ? iss_q[3] : 32'd0, 32'h3C003C00);
    adder_lat = LAT;

    // Random bursts of small integers (exact in FP16) with occasional gaps.
    for (int r = 0; r < 12; r++) begin
      bq.delete();
      n   = $urandom_range(1, 12);
      tot = 0;
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(0, 31);
        tot += v;
        bq.push_back(fp_enc(real'(v)));
      end
      run_burst($sformatf("rnd%0d", r), bq, fp_enc(real'(tot)), n - 1, 1'b1);
    end

    // Reset in DRAIN with two pairs in flight.
    iss_q.delete();
    for (int i = 0; i < 4; i++) send_beat(16'h3C00, i == 3);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("drain_add_valid_pre", 32'(add_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_add_valid", 32'(add_valid), 32'd0);
    chk("abort_sum_valid", 32'(sum_valid), 32'd0);
    repeat (2) @(negedge clk);
    sv0   = sumv_cnt;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_sum", 32'(sumv_cnt), 32'(sv0));
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_err", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
